robot_nav: RTL and testbench

ROBOT_NAV -- requirements
Module: robot_nav

---
 rtl/robot_nav_pkg.sv | 17 +
 rtl/robot_nav_if.sv | 20 ++
 rtl/robot_nav_sensor_debounce.sv | 46 ++++
 rtl/robot_nav.sv | 159 +++++++++++++++
 tb/tb_robot_nav.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/robot_nav_pkg.sv
// Shared state encodings and counter-width helper for the robot navigation controller.
package robot_pkg;

  typedef enum logic [2:0] {
    NO_ENTRY = 3'd0,
    FOLLOW   = 3'd1,
    TURN_R   = 3'd2,
    TURN_L   = 3'd3,
    UTURN    = 3'd4
  } nav_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/robot_nav_if.sv
// Sensor inputs and motion/debug outputs of the robot navigation controller.
interface robot_nav_if;
  logic       front_sensor;
  logic       left_sensor;
  logic       front;
  logic       turn;
  logic       turn_left;
  logic       stuck;
  logic [2:0] state_o;

  modport master (
    output front_sensor, left_sensor,
    input  front, turn, turn_left, stuck, state_o
  );

  modport slave (
    input  front_sensor, left_sensor,
    output front, turn, turn_left, stuck, state_o
  );
endinterface

// File: rtl/robot_nav_sensor_debounce.sv
// Single-sensor debouncer: filtered follows raw after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce
  import robot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            filt_q, filt_d;

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (raw != filt_q) begin
      // Counter returns to zero on the same edge the filtered value flips.
      if (cnt_inc == CntMax) begin
        filt_d = raw;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filtered = filt_q;

endmodule

// File: rtl/robot_nav.sv
// Wall-following navigation FSM with debounced sensors and timed turns.
// Optional U-turn escape after repeated blocked right turns: ROBOT_NAV_STUCK_DETECT_EN.
module robot_nav
  import robot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned TURN_CYCLES     = 4,
  parameter int unsigned STUCK_LIMIT     = 3
) (
  input logic        clk,
  input logic        reset,
  robot_nav_if.slave nav
);

  localparam int unsigned TurnW = cnt_width(2 * TURN_CYCLES);
  localparam logic [TurnW-1:0] TurnLast = TurnW'(TURN_CYCLES - 1);

  logic f, l;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_front_db (
    .clk      (clk),
    .reset    (reset),
    .raw      (nav.front_sensor),
    .filtered (f)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left_db (
    .clk      (clk),
    .reset    (reset),
    .raw      (nav.left_sensor),
    .filtered (l)
  );

  nav_state_e       state_q, state_d;
  logic [TurnW-1:0] tcnt_q, tcnt_d;
  logic             restart;

`ifdef ROBOT_NAV_STUCK_DETECT_EN
  localparam int unsigned StuckW = cnt_width(STUCK_LIMIT);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_LIMIT);
  localparam logic [TurnW-1:0] UturnLast = TurnW'(2 * TURN_CYCLES - 1);

  logic [StuckW-1:0] stuck_q, stuck_d, stuck_inc;

  assign stuck_inc = (stuck_q == StuckMax) ? stuck_q : stuck_q + StuckW'(1);
`endif

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      NO_ENTRY: begin
        if (f) begin
          state_d = TURN_R;
        end else if (l) begin
          state_d = FOLLOW;
        end
      end
      FOLLOW: begin
        if (f) begin
          state_d = TURN_R;
        end else if (!l) begin
          state_d = TURN_L;
        end
      end
      TURN_R: begin
        if (tcnt_q == TurnLast) begin
          if (f) begin
`ifdef ROBOT_NAV_STUCK_DETECT_EN
            if (stuck_inc == StuckMax) begin
              state_d = UTURN;
            end else begin
              restart = 1'b1;
            end
`else
            restart = 1'b1;
`endif
          end else if (l) begin
            state_d = FOLLOW;
          end else begin
            state_d = NO_ENTRY;
          end
        end
      end
      TURN_L: begin
        if (tcnt_q == TurnLast) begin
          state_d = NO_ENTRY;
        end
      end
`ifdef ROBOT_NAV_STUCK_DETECT_EN
      UTURN: begin
        if (tcnt_q == UturnLast) begin
          state_d = NO_ENTRY;
        end
      end
`endif
      default: state_d = NO_ENTRY;
    endcase
  end

  // The turn timer only runs inside turning states and restarts on every entry.
  always_comb begin
    tcnt_d = '0;
    if ((state_d == state_q) && !restart &&
        (state_q == TURN_R || state_q == TURN_L || state_q == UTURN)) begin
      tcnt_d = tcnt_q + TurnW'(1);
    end
  end

`ifdef ROBOT_NAV_STUCK_DETECT_EN
  always_comb begin
    stuck_d = stuck_q;
    if (state_d == NO_ENTRY || state_d == FOLLOW) begin
      stuck_d = '0;
    end else if (state_q == TURN_R && (restart || state_d == UTURN)) begin
      stuck_d = stuck_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_q <= '0;
    end else begin
      stuck_q <= stuck_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NO_ENTRY;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    nav.front     = 1'b0;
    nav.turn      = 1'b0;
    nav.turn_left = 1'b0;
    unique case (state_q)
      NO_ENTRY, FOLLOW: nav.front     = 1'b1;
      TURN_R, UTURN:    nav.turn      = 1'b1;
      TURN_L:           nav.turn_left = 1'b1;
      default:          nav.front     = 1'b1;
    endcase
  end

`ifdef ROBOT_NAV_STUCK_DETECT_EN
  assign nav.stuck = (state_q == UTURN);
`else
  assign nav.stuck = 1'b0;
`endif

  assign nav.state_o = state_q;

endmodule

// File: tb/tb_robot_nav.sv
// Scoreboard bench for robot_nav: directed sensor vectors with hand-derived expected states.
module tb_robot_nav;

  localparam logic [2:0] SNo = 3'd0;
  localparam logic [2:0] SFo = 3'd1;
  localparam logic [2:0] STr = 3'd2;
  localparam logic [2:0] STl = 3'd3;
  localparam logic [2:0] SUt = 3'd4;

  typedef struct {
    string      tag;
    logic [2:0] st;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sb[$];

  robot_nav_if nav_if ();

  robot_nav #(
    .DEBOUNCE_CYCLES (2),
    .TURN_CYCLES     (4),
    .STUCK_LIMIT     (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .nav   (nav_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {front, turn, turn_left, stuck} for a given state.
  function automatic logic [3:0] outs_of(input logic [2:0] st);
    case (st)
      SNo, SFo: return 4'b1000;
      STr:      return 4'b0100;
      STl:      return 4'b0010;
      SUt:      return 4'b0101;
      default:  return 4'b0000;
    endcase
  endfunction

  // Drive one cycle of inputs; st is the state expected after the next rising edge.
  task automatic step(input logic r, input logic fs, input logic ls, input logic [2:0] st,
                      input string tag);
    exp_t e;
    @(negedge clk);
    reset               = r;
    nav_if.front_sensor = fs;
    nav_if.left_sensor  = ls;
    e.tag = tag;
    e.st  = st;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [3:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {nav_if.front, nav_if.turn, nav_if.turn_left, nav_if.stuck};
        total++;
        if (nav_if.state_o !== e.st) begin
          bad++;
          $display("FAIL %s state: got %0d expected %0d", e.tag, nav_if.state_o, e.st);
        end
        total++;
        if (got !== outs_of(e.st)) begin
          bad++;
          $display("FAIL %s outputs(f,t,tl,s): got %b expected %b", e.tag, got, outs_of(e.st));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [2:0] exp_ut;
    logic [2:0] exp_after;
`ifdef ROBOT_NAV_STUCK_DETECT_EN
    exp_ut    = SUt;
    exp_after = SNo;
`else
    exp_ut    = STr;
    exp_after = STr;
`endif
    total = 0;
    bad   = 0;
    reset = 1'b1;
    nav_if.front_sensor = 1'b0;
    nav_if.left_sensor  = 1'b0;

    step(1, 0, 0, SNo, "reset0");
    step(1, 0, 0, SNo, "reset1");

    // Left wall appears: filtered on edge 2, FOLLOW on edge 3.
    step(0, 0, 1, SNo, "left_e1");
    step(0, 0, 1, SNo, "left_e2");
    step(0, 0, 1, SFo, "left_e3");
    step(0, 0, 1, SFo, "follow_hold");

    // One-cycle obstacle glitch is filtered out.
    step(0, 1, 1, SFo, "glitch_on");
    step(0, 0, 1, SFo, "glitch_off");
    step(0, 0, 1, SFo, "glitch_after0");
    step(0, 0, 1, SFo, "glitch_after1");

    // Wall lost: timed left turn of 4 cycles, then NO_ENTRY.
    step(0, 0, 0, SFo, "drop_e1");
    step(0, 0, 0, SFo, "drop_e2");
    for (int i = 0; i < 4; i++) step(0, 0, 0, STl, "turn_l");
    step(0, 0, 0, SNo, "turn_l_done");
    step(0, 0, 0, SNo, "no_entry_hold");

    // Reset in the middle of a left turn.
    step(0, 0, 1, SNo, "re_left_e1");
    step(0, 0, 1, SNo, "re_left_e2");
    step(0, 0, 1, SFo, "re_follow");
    step(0, 0, 0, SFo, "re_drop_e1");
    step(0, 0, 0, SFo, "re_drop_e2");
    step(0, 0, 0, STl, "re_turn_l0");
    step(0, 0, 0, STl, "re_turn_l1");
    step(1, 0, 0, SNo, "reset_mid_turn_l");
    step(0, 0, 0, SNo, "after_reset_l");

    // Obstacle held: three blocked right turns, then U-turn (or endless right turn).
    step(0, 1, 0, SNo, "blk_e1");
    step(0, 1, 0, SNo, "blk_e2");
    for (int i = 0; i < 12; i++) step(0, 1, 0, STr, "blocked_turn_r");
    for (int i = 0; i < 8; i++) step(0, 1, 0, exp_ut, "uturn");
    step(0, 1, 0, exp_after, "uturn_exit");
    step(0, 1, 0, STr, "turn_r_again");
    step(1, 1, 0, SNo, "reset_mid_turn_r");
    step(0, 0, 0, SNo, "after_reset_r");

    // Obstacle clears during a right turn with wall present: FOLLOW at the terminal cycle.
    step(0, 1, 1, SNo, "both_e1");
    step(0, 1, 1, SNo, "both_e2");
    step(0, 1, 1, STr, "turn_r_enter");
    for (int i = 0; i < 3; i++) step(0, 0, 1, STr, "turn_r_ignore");
    step(0, 0, 1, SFo, "turn_r_to_follow");

    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
